// File: rtl/shifter.sv
// shifter: registered 32-bit logical barrel shifter
// log-stage datapath, one-cycle latency
module shifter #(
  parameter int WIDTH = 32,
  parameter int SHAMT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] toshift,
  input  logic [SHAMT-1:0] number,
  input  logic             direction,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] stage [SHAMT+1];

  assign stage[0] = toshift;

  for (genvar k = 0; k < SHAMT; k++) begin : g_stage
    logic [WIDTH-1:0] sl;
    logic [WIDTH-1:0] sr;
    assign sl = stage[k] << (1 << k);
    assign sr = stage[k] >> (1 << k);
    // stage k moves by 2^k when its amount bit is set
    always_comb begin
      stage[k+1] = stage[k];
      if (number[k])
        stage[k+1] = direction ? sr : sl;
    end
  end

  // capture the shift result every edge; async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shifted <= '0;
    else
      shifted <= stage[SHAMT];
  end

endmodule

// File: tb/tb_shifter.sv
// tb_shifter: scoreboard bench for shifter
// driver pushes expectations, monitor pops
module tb_shifter;

  logic        clk;
  logic        rst_n;
  logic [31:0] toshift;
  logic [4:0]  number;
  logic        direction;
  logic [31:0] shifted;

  typedef struct {
    logic [31:0] v;
    string       n;
  } exp_t;

  exp_t q[$];
  int checks;
  int failures;

  shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .toshift   (toshift),
    .number    (number),
    .direction (direction),
    .shifted   (shifted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       n,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               n, act, req);
    end
  endtask

  task automatic apply(
    input logic [31:0] ts,
    input logic [4:0]  n,
    input logic        d,
    input logic [31:0] e,
    input string       nm
  );
    exp_t x;
    toshift   = ts;
    number    = n;
    direction = d;
    x.v = e;
    x.n = nm;
    q.push_back(x);
  endtask

  task automatic drive(
    input logic [31:0] ts,
    input logic [4:0]  n,
    input logic        d,
    input logic [31:0] e,
    input string       nm
  );
    @(negedge clk);
    apply(ts, n, d, e, nm);
  endtask

  // monitor: one result per edge for each queued operand
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      check(x.n, shifted, x.v);
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    toshift   = '0;
    number    = '0;
    direction = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset", shifted, 32'h0);
    @(posedge clk);
    #1 check("reset_hold", shifted, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(32'h8000_0000, 5'd31, 1'b1,
          32'h0000_0001, "r_max");
    drive(32'h0000_0001, 5'd31, 1'b0,
          32'h8000_0000, "l_max");
    drive(32'hFFFF_FFFF, 5'd4, 1'b1,
          32'h0FFF_FFFF, "zfill_r");
    drive(32'hFFFF_FFFF, 5'd4, 1'b0,
          32'hFFFF_FFF0, "zfill_l");
    drive(32'hA5A5_A5A5, 5'd0, 1'b0,
          32'hA5A5_A5A5, "pass_l");
    drive(32'hA5A5_A5A5, 5'd0, 1'b1,
          32'hA5A5_A5A5, "pass_r");
    drive(32'h1234_5678, 5'd8, 1'b0,
          32'h3456_7800, "mid_l");
    drive(32'h1234_5678, 5'd12, 1'b1,
          32'h0001_2345, "mid_r");
    drive(32'h8000_0001, 5'd31, 1'b1,
          32'h0000_0001, "r31_one");
    drive(32'h0000_0001, 5'd1, 1'b0,
          32'h0000_0002, "tp0");
    drive(32'h0000_0080, 5'd7, 1'b1,
          32'h0000_0001, "tp1");
    drive(32'hF000_0000, 5'd28, 1'b1,
          32'h0000_000F, "tp2");

    // late input change: only the value at the edge counts
    @(negedge clk);
    toshift = 32'hDEAD_BEEF;
    number  = 5'd3;
    #2 apply(32'h0000_00FF, 5'd16, 1'b0,
             32'h00FF_0000, "late_chg");

    drive(32'h8000_0000, 5'd31, 1'b1,
          32'h0000_0001, "pre_rst");
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1 check("async_rst", shifted, 32'h0);
    @(posedge clk);
    #1 check("rst_held", shifted, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h0000_0003, 5'd2, 1'b0,
          32'h0000_000C, "resume");

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1);
  end

endmodule
